state_loader: RTL and testbench
===============================

Name: state_loader

Overview:
- Writer-side counterpart to the simulation state dump. After reset, the block accepts a stream of initialization records over a valid/ready handshake.
- It writes each record into the register file or data memory of the pipelined machine.
- It holds the machine in reset until an END record arrives, then releases it.
- It sits between the bench/host stream source and the machine's rf/data_memory write ports.

Parameters:
- MEM_BASE, 32'h10000000, byte address of data_seg word 0.
- MEM_WORDS, 32768, number of 32-bit words in data_seg; legal word index is 0..MEM_WORDS-1.
- CNT_W, 16, width of the accepted-write counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin load; sampled in IDLE only.
- in_valid  input  1  record present.
- in_ready  output  1  block accepts record this cycle.
- in_kind  input  2  0=REG, 1=MEM, 2=END, 3=reserved.
- in_addr  input  32  REG: register number in bits[4:0], bits[31:5] must be 0; MEM: byte address.
- in_data  input  32  write data; ignored for END.
- rf_we  output  1  register-file write strobe.
- rf_waddr  output  5  register number.
- rf_wdata  output  32  register data.
- mem_we  output  1  data-memory write strobe.
- mem_widx  output  15  word index (addr-MEM_BASE)>>2.
- mem_wdata  output  32  memory data.
- cpu_reset  output  1  reset to pipelined_machine.
- done  output  1  load complete.
- error  output  1  sticky: a bad record was seen.
- wr_count  output  CNT_W  number of writes issued.

Behaviour:
- FSM states: IDLE, LOAD, DONE. Reset enters IDLE.
- Reset values: rf_we=0, mem_we=0, all address/data outputs 0, cpu_reset=1, done=0, error=0, wr_count=0, in_ready=0.
- IDLE: in_ready=0. When start=1, go to LOAD on the next edge.
- LOAD: in_ready=1 every cycle; there is no backpressure. A record is accepted on any posedge with in_valid=1 and in_ready=1.
- Write strobes, addresses and data are registered. A record accepted at edge N drives its strobe for exactly the cycle after N, and the strobe drops at edge N+1 unless another record is accepted. Back-to-back records give continuous strobes.
- REG record:
  - bits[31:5] nonzero: set error, no write.
  - register 0: dropped silently (no write, no error, no count).
  - Otherwise rf_we=1 and wr_count increments.
- MEM record:
  - Legal only when in_addr>=MEM_BASE, in_addr[1:0]==0, and (in_addr-MEM_BASE)>>2 < MEM_WORDS.
  - Illegal: set error, no write.
  - Legal: mem_we=1 with mem_widx equal to the low 15 bits of the word index; wr_count increments.
  - Compute the subtraction in 32 bits; a borrow counts as out of range.
- kind 3: set error, no write, stay in LOAD.
- END record: go to DONE on the accepting edge and produce no write. Any write strobe from the previous record still completes in the following cycle.
- DONE:
  - in_ready=0, done=1, and cpu_reset=0 from the first DONE cycle.
  - Input is ignored and start is ignored.
  - The block stays in DONE until reset.
- cpu_reset=1 in IDLE and LOAD, 0 only in DONE. It is a registered output (state-decoded, glitch-free).
- wr_count saturates at all-ones and does not wrap.
- error is sticky until reset and does not stop loading.
- rf_we and mem_we are never asserted in the same cycle.
- Reset asserted mid-LOAD: on that edge return to IDLE, clear strobes, counters and error, and set cpu_reset=1. Writes already issued are not undone, and a record presented on that edge is discarded.
- start and a record presented in the same IDLE cycle: the record is not accepted (in_ready=0).

Test Plan:
- Reset 2 cycles, start, REG(addr=8, data=0x1234), END -> one cycle later rf_we=1, rf_waddr=8, rf_wdata=0x1234; next cycle cpu_reset=0, done=1, wr_count=1, error=0.
- MEM records 0x10010000, 0x10010004, 0x10010008 on back-to-back cycles -> mem_we high 3 consecutive cycles, mem_widx=16384, 16385, 16386, data matching; wr_count=3.
- MEM 0x10010002 (misaligned), MEM 0x0FFFFFFC (below base), MEM 0x10020000 (idx 32768) -> no mem_we, error=1, wr_count=0; a following legal REG(3) still writes.
- REG(0, 0xFFFFFFFF), REG(addr=0x20) -> no rf_we; error=1 only after the second; wr_count unchanged; kind=3 also sets error.
- Load 5 records, assert reset for 1 cycle mid-stream -> IDLE, cpu_reset=1, wr_count=0, error=0, in_ready=0; restart and END -> done=1.
- After END, drive in_valid=1 with REG(5) for 10 cycles -> in_ready=0, no rf_we, done stays 1, cpu_reset stays 0.

Source files
------------

// File: rtl/state_loader_if.sv
// Record stream from the host/bench source into the state loader.
// The master drives records; the slave (the loader) returns in_ready.
interface state_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [31:0] in_addr;
  logic [31:0] in_data;

  modport master (output in_valid, in_kind, in_addr, in_data, input in_ready);
  modport slave  (input in_valid, in_kind, in_addr, in_data, output in_ready);
endinterface

// File: rtl/state_loader.sv
// Loads register-file and data-memory initialisation records into the
// pipelined machine, holding it in reset until an END record is accepted.
//
// state | meaning
// IDLE  | waiting for start, machine held in reset
// LOAD  | accepting records every cycle, issuing writes
// DONE  | load complete, machine released until reset
module state_loader #(
  parameter logic [31:0] MEM_BASE  = 32'h1000_0000,
  parameter int unsigned MEM_WORDS = 32768,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  state_loader_if.slave    rec,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             mem_we,
  output logic [14:0]      mem_widx,
  output logic [31:0]      mem_wdata,
  output logic             cpu_reset,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [1:0]  K_REG   = 2'd0;
  localparam logic [1:0]  K_MEM   = 2'd1;
  localparam logic [1:0]  K_END   = 2'd2;
  localparam logic [31:0] MEM_LIM = 32'(MEM_WORDS);

  state_t           state;
  logic             ready_q;
  logic [32:0]      mem_off;
  logic             mem_ok;
  logic [CNT_W-1:0] cnt_inc;

  assign rec.in_ready = ready_q;

  // 33-bit subtraction so a borrow (address below the base) is visible in bit 32.
  assign mem_off = {1'b0, rec.in_addr} - {1'b0, MEM_BASE};
  assign mem_ok  = !mem_off[32] && (rec.in_addr[1:0] == 2'b00) &&
                   ({2'b00, mem_off[31:2]} < MEM_LIM);
  assign cnt_inc = (&wr_count) ? wr_count : wr_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      mem_we    <= 1'b0;
      mem_widx  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      wr_count  <= '0;
    end else begin
      rf_we  <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (rec.in_valid) begin
            case (rec.in_kind)
              K_REG: begin
                if (rec.in_addr[31:5] != '0) begin
                  error <= 1'b1;
                end else if (rec.in_addr[4:0] != 5'd0) begin
                  rf_we    <= 1'b1;
                  rf_waddr <= rec.in_addr[4:0];
                  rf_wdata <= rec.in_data;
                  wr_count <= cnt_inc;
                end
              end
              K_MEM: begin
                if (mem_ok) begin
                  mem_we    <= 1'b1;
                  mem_widx  <= mem_off[16:2];
                  mem_wdata <= rec.in_data;
                  wr_count  <= cnt_inc;
                end else begin
                  error <= 1'b1;
                end
              end
              K_END: begin
                state     <= DONE;
                ready_q   <= 1'b0;
                done      <= 1'b1;
                cpu_reset <= 1'b0;
              end
              default: error <= 1'b1;
            endcase
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_state_loader.sv
// Directed bench for state_loader: hand-computed expectations per record.
module tb_state_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        rf_we, mem_we, cpu_reset, done, error;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, mem_wdata;
  logic [14:0] mem_widx;
  logic [15:0] wr_count;
  int          total = 0;
  int          bad = 0;

  state_loader_if ifc ();

  state_loader dut (
    .clk(clk), .reset(reset), .start(start), .rec(ifc.slave),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_widx(mem_widx), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
    ifc.in_valid = 1'b1;
    ifc.in_kind  = kind;
    ifc.in_addr  = addr;
    ifc.in_data  = data;
  endtask

  task automatic idle_in();
    ifc.in_valid = 1'b0;
    ifc.in_kind  = 2'd0;
    ifc.in_addr  = 32'd0;
    ifc.in_data  = 32'd0;
  endtask

  task automatic restart();
    idle_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    idle_in();
    // reset state
    step();
    step();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_in_ready", ifc.in_ready, 0);
    chk("rst_waddr", rf_waddr, 0);

    // basic REG then END
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_in_ready", ifc.in_ready, 1);
    chk("load_cpu_reset", cpu_reset, 1);
    put(2'd0, 32'd8, 32'h1234);
    step();
    chk("reg8_we", rf_we, 1);
    chk("reg8_addr", rf_waddr, 8);
    chk("reg8_data", rf_wdata, 32'h1234);
    chk("reg8_mem_we", mem_we, 0);
    put(2'd2, 32'd0, 32'd0);
    step();
    idle_in();
    chk("end_rf_we", rf_we, 0);
    chk("end_done", done, 1);
    chk("end_cpu_reset", cpu_reset, 0);
    chk("end_wr_count", wr_count, 1);
    chk("end_error", error, 0);
    chk("end_in_ready", ifc.in_ready, 0);

    // back-to-back MEM writes
    restart();
    for (int i = 0; i < 3; i++) begin
      put(2'd1, 32'h1001_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      step();
      chk("mem_we", mem_we, 1);
      chk("mem_widx", mem_widx, 32'(16384 + i));
      chk("mem_wdata", mem_wdata, 32'hA000_0000 + 32'(i));
      chk("mem_rf_we", rf_we, 0);
    end
    idle_in();
    step();
    chk("mem_we_drop", mem_we, 0);
    chk("mem_wr_count", wr_count, 3);
    chk("mem_error", error, 0);

    // illegal MEM records, then a legal REG
    restart();
    put(2'd1, 32'h1001_0002, 32'h1);
    step();
    chk("misal_we", mem_we, 0);
    chk("misal_err", error, 1);
    put(2'd1, 32'h0FFF_FFFC, 32'h2);
    step();
    chk("below_we", mem_we, 0);
    put(2'd1, 32'h1002_0000, 32'h3);
    step();
    chk("over_we", mem_we, 0);
    chk("bad_mem_err", error, 1);
    chk("bad_mem_cnt", wr_count, 0);
    put(2'd1, 32'h1001_FFFC, 32'h4);
    step();
    chk("top_word_we", mem_we, 1);
    chk("top_word_idx", mem_widx, 32767);
    put(2'd0, 32'd3, 32'hCAFE);
    step();
    chk("reg3_we", rf_we, 1);
    chk("reg3_addr", rf_waddr, 3);
    chk("reg3_cnt", wr_count, 2);
    chk("reg3_err_sticky", error, 1);

    // register 0, out-of-range register, reserved kind
    restart();
    put(2'd0, 32'd0, 32'hFFFF_FFFF);
    step();
    chk("r0_we", rf_we, 0);
    chk("r0_err", error, 0);
    chk("r0_cnt", wr_count, 0);
    put(2'd0, 32'h20, 32'h5);
    step();
    chk("r32_we", rf_we, 0);
    chk("r32_err", error, 1);
    chk("r32_cnt", wr_count, 0);
    restart();
    put(2'd3, 32'd4, 32'h6);
    step();
    chk("k3_err", error, 1);
    chk("k3_we", rf_we | mem_we, 0);
    chk("k3_stay_load", ifc.in_ready, 1);

    // reset mid-stream, start with a record in IDLE
    restart();
    for (int i = 1; i <= 4; i++) begin
      put(2'd0, 32'(i), 32'(i));
      step();
    end
    put(2'd3, 32'd0, 32'd0);
    step();
    chk("mid_cnt", wr_count, 4);
    chk("mid_err", error, 1);
    put(2'd0, 32'd7, 32'h77);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_ready", ifc.in_ready, 0);
    chk("mrst_cpu_reset", cpu_reset, 1);
    chk("mrst_cnt", wr_count, 0);
    chk("mrst_err", error, 0);
    chk("mrst_rf_we", rf_we, 0);
    start = 1'b1;
    put(2'd0, 32'd6, 32'h66);
    step();
    start = 1'b0;
    chk("idle_rec_we", rf_we, 0);
    chk("idle_rec_cnt", wr_count, 0);
    chk("idle_to_load", ifc.in_ready, 1);
    put(2'd2, 32'd0, 32'd0);
    step();
    chk("restart_done", done, 1);

    // input and start ignored after DONE
    put(2'd0, 32'd5, 32'h55);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("dn_ready", ifc.in_ready, 0);
      chk("dn_rf_we", rf_we, 0);
      chk("dn_done", done, 1);
      chk("dn_cpu_reset", cpu_reset, 0);
    end
    start = 1'b0;
    chk("dn_cnt", wr_count, 0);

    // counter saturation
    restart();
    put(2'd0, 32'd1, 32'd1);
    for (int i = 0; i < 65534; i++) step();
    chk("sat_pre", wr_count, 16'hFFFE);
    step();
    chk("sat_full", wr_count, 16'hFFFF);
    step();
    step();
    chk("sat_hold", wr_count, 16'hFFFF);
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
